// File: rtl/sync_pkg.sv
// Shared types for the clko-side event drain: FSM state encoding and the
// width helper used to size the inter-event gap counter.
package sync_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // A zero gap still needs a 1-bit counter so the port/register stays legal.
  function automatic int gap_cnt_w(input int gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter for queued events; flags an increment lost at
// full scale and exposes whether the next value will be non-zero.
module sat_updown_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clko,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_stb,
  output logic             nxt_nz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_nxt;

  // Simultaneous inc/dec cancel; each direction clamps at its rail.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic             up,
                                                input logic             dn);
    logic [CNT_W-1:0] r;
    r = c;
    if (up && !dn) begin
      if (c != CNT_MAX) r = c + CNT_W'(1);
    end else if (dn && !up) begin
      if (c != '0) r = c - CNT_W'(1);
    end
    return r;
  endfunction

  assign cnt_nxt = sat_step(cnt, inc, dec);
  assign ovf_stb = inc && !dec && (cnt == CNT_MAX);
  assign nxt_nz  = (cnt_nxt != '0);

  always_ff @(posedge clko or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/pulse_event_drain.sv
// Queues synchronized one-cycle event pulses and releases them one at a time
// over valid/ready, optionally spacing releases by GAP idle cycles.
module pulse_event_drain
  import sync_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clko,
  input  logic             rst,
  input  logic             ev_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [CNT_W-1:0] pending_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i,
  output logic             idle_o
);

  localparam int            GW       = gap_cnt_w(GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  state_e           state, state_nxt;
  logic [GW-1:0]    gap_cnt;
  logic [CNT_W-1:0] pending;
  logic             xfer;
  logic             pend_nz_nxt;
  logic             ovf_stb;
  logic             ovf;

  // A transfer can only happen while offering, so ready is ignored otherwise.
  assign xfer = (state == S_ISSUE) && evt_ready_i;

  sat_updown_cnt #(
    .CNT_W(CNT_W)
  ) u_pending (
    .clko    (clko),
    .rst     (rst),
    .inc     (ev_i),
    .dec     (xfer),
    .cnt     (pending),
    .ovf_stb (ovf_stb),
    .nxt_nz  (pend_nz_nxt)
  );

  always_ff @(posedge clko or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pend_nz_nxt) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (xfer) begin
          if (GAP == 0) state_nxt = pend_nz_nxt ? S_ISSUE : S_IDLE;
          else          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // <= 1 rather than == 1 so a corrupted zero count cannot park here.
        if (gap_cnt <= GW'(1)) state_nxt = pend_nz_nxt ? S_ISSUE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    evt_valid_o = (state == S_ISSUE);
    idle_o      = (state == S_IDLE) && (pending == '0);
    pending_o   = pending;
    ovf_o       = ovf;
  end

  always_ff @(posedge clko or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (xfer) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == S_GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clko or posedge rst) begin
    if (rst)            ovf <= 1'b0;
    else if (ovf_stb)   ovf <= 1'b1;
    else if (ovf_clr_i) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_pulse_event_drain.sv
// Directed bench for pulse_event_drain: a per-cycle vector table on a default
// instance plus hand sequences for gap spacing, saturation and async reset.
module tb_pulse_event_drain;

  logic clko = 1'b0;
  logic rst  = 1'b1;

  always #5 clko = ~clko;

  // Default instance: CNT_W=8, GAP=0
  logic       ev0 = 0, rdy0 = 0, clr0 = 0;
  logic       v0, o0, i0;
  logic [7:0] p0;
  // Gap instance: CNT_W=8, GAP=2
  logic       evg = 0, rdyg = 0, clrg = 0;
  logic       vg, og, ig;
  logic [7:0] pg;
  // Saturation instance: CNT_W=2, GAP=0
  logic       evs = 0, rdys = 0, clrs = 0;
  logic       vs, os, is_;
  logic [1:0] ps;

  pulse_event_drain #(.CNT_W(8), .GAP(0)) dut0 (
    .clko(clko), .rst(rst), .ev_i(ev0), .evt_valid_o(v0), .evt_ready_i(rdy0),
    .pending_o(p0), .ovf_o(o0), .ovf_clr_i(clr0), .idle_o(i0));

  pulse_event_drain #(.CNT_W(8), .GAP(2)) dut_gap (
    .clko(clko), .rst(rst), .ev_i(evg), .evt_valid_o(vg), .evt_ready_i(rdyg),
    .pending_o(pg), .ovf_o(og), .ovf_clr_i(clrg), .idle_o(ig));

  pulse_event_drain #(.CNT_W(2), .GAP(0)) dut_sat (
    .clko(clko), .rst(rst), .ev_i(evs), .evt_valid_o(vs), .evt_ready_i(rdys),
    .pending_o(ps), .ovf_o(os), .ovf_clr_i(clrs), .idle_o(is_));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clko);
    #1;
  endtask

  typedef struct {
    logic ev;
    logic rdy;
    logic clr;
    logic v;
    int   p;
    logic o;
    logic idl;
  } vec_t;

  vec_t vt[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:11] pat;
    int          xfers;

    // Outputs must be at reset values while rst is held.
    #12;
    chk("rst_valid", v0, 0);
    chk("rst_pend",  p0, 0);
    chk("rst_ovf",   o0, 0);
    chk("rst_idle",  i0, 1);
    chk("rst_sat_idle", is_, 1);
    chk("rst_gap_idle", ig, 1);
    @(negedge clko);
    rst = 1'b0;
    tick();

    // {ev, rdy, clr} applied for one cycle -> {valid, pending, ovf, idle} after the edge
    // single event, ready tied high (ready while idle is ignored)
    vt.push_back('{0,1,0, 0,0,0,1});
    vt.push_back('{0,1,0, 0,0,0,1});
    vt.push_back('{1,1,0, 1,1,0,0});
    vt.push_back('{0,1,0, 0,0,0,1});
    vt.push_back('{0,1,0, 0,0,0,1});
    // three back-to-back events, ready high throughout
    vt.push_back('{1,1,0, 1,1,0,0});
    vt.push_back('{1,1,0, 1,1,0,0});
    vt.push_back('{1,1,0, 1,1,0,0});
    vt.push_back('{0,1,0, 0,0,0,1});
    // three events with ready held off for two cycles: queue reaches 2
    vt.push_back('{1,0,0, 1,1,0,0});
    vt.push_back('{1,0,0, 1,2,0,0});
    vt.push_back('{1,1,0, 1,2,0,0});
    vt.push_back('{0,1,0, 1,1,0,0});
    vt.push_back('{0,1,0, 0,0,0,1});
    // stalled offer, then event and ready in the same cycle
    vt.push_back('{1,0,0, 1,1,0,0});
    vt.push_back('{0,0,0, 1,1,0,0});
    vt.push_back('{1,1,0, 1,1,0,0});
    vt.push_back('{0,1,1, 0,0,0,1});

    foreach (vt[k]) begin
      ev0 = vt[k].ev; rdy0 = vt[k].rdy; clr0 = vt[k].clr;
      tick();
      chk($sformatf("vec%0d_valid", k), v0, vt[k].v);
      chk($sformatf("vec%0d_pend",  k), p0, vt[k].p);
      chk($sformatf("vec%0d_ovf",   k), o0, vt[k].o);
      chk($sformatf("vec%0d_idle",  k), i0, vt[k].idl);
    end
    ev0 = 0; rdy0 = 0; clr0 = 0;

    // Saturation on the 2-bit counter with the consumer stalled
    rdys = 0;
    for (int k = 1; k <= 5; k++) begin
      evs = 1;
      tick();
      chk($sformatf("sat_pend_%0d", k), ps, (k > 3) ? 3 : k);
      chk($sformatf("sat_ovf_%0d", k),  os, (k > 3) ? 1 : 0);
    end
    evs = 1; clrs = 1;
    tick();
    chk("sat_clr_vs_set_ovf", os, 1);
    chk("sat_clr_vs_set_pend", ps, 3);
    evs = 0; clrs = 1;
    tick();
    chk("sat_clr_ovf", os, 0);
    clrs = 0;
    rdys = 1;
    xfers = 0;
    for (int k = 0; k < 8; k++) begin
      if (vs) xfers++;
      tick();
    end
    chk("sat_xfers", xfers, 3);
    chk("sat_final_pend", ps, 0);
    chk("sat_final_idle", is_, 1);
    rdys = 0;

    // GAP=2 spacing: queue three events, then release ready
    rdyg = 0;
    for (int k = 0; k < 3; k++) begin
      evg = 1;
      tick();
    end
    evg = 0;
    chk("gap_queued_pend", pg, 3);
    chk("gap_queued_valid", vg, 1);
    pat = 12'b1001_0010_0000;
    rdyg = 1;
    xfers = 0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("gap_trace_%0d", k), vg, pat[k]);
      if (vg) xfers++;
      tick();
    end
    chk("gap_xfers", xfers, 3);
    chk("gap_final_pend", pg, 0);
    chk("gap_final_idle", ig, 1);
    rdyg = 0;

    // Async reset in the middle of a gap with four events still queued
    for (int k = 0; k < 5; k++) begin
      evg = 1;
      tick();
    end
    evg = 0;
    chk("mid_pre_pend", pg, 5);
    rdyg = 1;
    tick();
    rdyg = 0;
    chk("mid_gap_valid", vg, 0);
    chk("mid_gap_pend", pg, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", vg, 0);
    chk("async_rst_pend",  pg, 0);
    chk("async_rst_ovf",   og, 0);
    chk("async_rst_idle",  ig, 1);
    #2 rst = 1'b0;
    evg = 1;
    tick();
    evg = 0;
    chk("post_rst_valid", vg, 1);
    chk("post_rst_pend",  pg, 1);
    chk("post_rst_idle",  ig, 0);
    tick();
    chk("post_rst_hold_valid", vg, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
